// File: rtl/line_frame_ctrl.sv
// Frame sequencer for the pixel-counter line interface: gates the line enable,
// counts completed lines, inserts a blanking gap and flags end of frame.
module line_frame_ctrl #(
  parameter int LINE_W       = 10,
  parameter int NORMAL_LINES = 960,
  parameter int TEST_LINES   = 16,
  parameter int BLANK_CYC    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              test,
  input  logic              endLine,
  output logic              line_enb,
  output logic [LINE_W-1:0] line_cnt,
  output logic              end_frame,
  output logic              busy
);

  localparam int BLK_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BLK_W-1:0]  BLK_LOAD    = BLK_W'(BLANK_CYC - 1);
  localparam logic [LINE_W-1:0] LAST_NORMAL = LINE_W'(NORMAL_LINES - 1);
  localparam logic [LINE_W-1:0] LAST_TEST   = LINE_W'(TEST_LINES - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, DONE} state_t;

  state_t             state_q, state_d;
  logic               test_q, test_d;
  logic [BLK_W-1:0]   blank_q, blank_d;
  logic               enb_d, ef_d, busy_d;
  logic [LINE_W-1:0]  cnt_d;
  logic [LINE_W-1:0]  last_line;

  assign last_line = test_q ? LAST_TEST : LAST_NORMAL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      line_enb  <= 1'b0;
      line_cnt  <= '0;
      end_frame <= 1'b0;
      busy      <= 1'b0;
      test_q    <= 1'b0;
      blank_q   <= '0;
    end else begin
      state_q   <= state_d;
      line_enb  <= enb_d;
      line_cnt  <= cnt_d;
      end_frame <= ef_d;
      busy      <= busy_d;
      test_q    <= test_d;
      blank_q   <= blank_d;
    end
  end

  always_comb begin
    state_d = state_q;
    enb_d   = line_enb;
    cnt_d   = line_cnt;
    ef_d    = 1'b0;
    busy_d  = busy;
    test_d  = test_q;
    blank_d = blank_q;
    // abort outranks every other event once a frame is running
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      enb_d   = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = ACTIVE;
            cnt_d   = '0;
            test_d  = test;
            busy_d  = 1'b1;
            enb_d   = 1'b1;
          end
        end
        ACTIVE: begin
          if (endLine) begin
            enb_d = 1'b0;
            if (line_cnt == last_line) begin
              state_d = DONE;
              ef_d    = 1'b1;
            end else begin
              state_d = BLANK;
              cnt_d   = line_cnt + LINE_W'(1);
              blank_d = BLK_LOAD;
            end
          end
        end
        BLANK: begin
          if (blank_q == '0) begin
            state_d = ACTIVE;
            enb_d   = 1'b1;
          end else begin
            blank_d = blank_q - BLK_W'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_frame_ctrl.sv
// Randomized bench for line_frame_ctrl: a frame-level reference model predicts
// every cycle's outputs into a queue, a monitor pops and compares on each cycle.
module tb_line_frame_ctrl;

  localparam int LINE_W       = 10;
  localparam int NORMAL_LINES = 960;
  localparam int TEST_LINES   = 16;
  localparam int BLANK_CYC    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              test = 1'b0;
  logic              endLine = 1'b0;
  logic              line_enb;
  logic [LINE_W-1:0] line_cnt;
  logic              end_frame;
  logic              busy;

  line_frame_ctrl #(
    .LINE_W(LINE_W), .NORMAL_LINES(NORMAL_LINES),
    .TEST_LINES(TEST_LINES), .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .test(test),
    .endLine(endLine), .line_enb(line_enb), .line_cnt(line_cnt),
    .end_frame(end_frame), .busy(busy)
  );

  always #8 clk = ~clk;

  typedef struct packed {
    logic              enb;
    logic [LINE_W-1:0] cnt;
    logic              ef;
    logic              bsy;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   errs = 0;
  int   ef_seen = 0;

  // Reference model: a frame is a sequence of lines; a line ends on endLine
  // while enabled, then a gap of BLANK_CYC cycles; the final line raises a
  // one-cycle end-of-frame flag instead of a gap.
  bit m_busy, m_enb, m_ef;
  int m_line, m_lines, m_gap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_enb = 0; m_ef = 0; m_line = 0; m_lines = NORMAL_LINES; m_gap = 0;
    end else begin
      if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1; m_enb = 1; m_line = 0;
          m_lines = test ? TEST_LINES : NORMAL_LINES;
        end
      end else if (abort) begin
        m_busy = 0; m_enb = 0; m_ef = 0;
      end else if (m_ef) begin
        m_ef = 0; m_busy = 0;
      end else if (m_enb) begin
        if (endLine) begin
          m_enb = 0;
          if (m_line + 1 == m_lines) m_ef = 1;
          else begin m_line++; m_gap = BLANK_CYC; end
        end
      end else begin
        m_gap--;
        if (m_gap == 0) m_enb = 1;
      end
      q.push_back({m_enb, LINE_W'(m_line), m_ef, m_busy});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      vecs++;
      if ({line_enb, line_cnt, end_frame, busy} !== '0) begin
        errs++;
        $display("FAIL reset_state: enb=%b cnt=%0d ef=%b busy=%b, want all 0",
                 line_enb, line_cnt, end_frame, busy);
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      vecs++;
      if ({line_enb, line_cnt, end_frame, busy} !== e) begin
        errs++;
        $display("FAIL cycle @%0t: enb=%b cnt=%0d ef=%b busy=%b, want enb=%b cnt=%0d ef=%b busy=%b",
                 $time, line_enb, line_cnt, end_frame, busy, e.enb, e.cnt, e.ef, e.bsy);
      end
    end
    if (end_frame === 1'b1) ef_seen++;
  end

  // Pixel-counter stand-in: mode 0 periodic line of plen enable cycles,
  // 1 random strobes, 2 silent, 3 periodic plus strobes while enable is low.
  int run = 0;
  int plen = 8;
  int pmode = 2;

  task automatic tick();
    @(negedge clk);
    if (line_enb === 1'b1) run++; else run = 0;
    start = 1'b0;
    abort = 1'b0;
    case (pmode)
      0:       endLine = (run == plen);
      1:       endLine = ($urandom_range(3) == 0);
      2:       endLine = 1'b0;
      default: endLine = (run == plen) || (line_enb !== 1'b1);
    endcase
  endtask

  task automatic check(input string name, input int act, input int want);
    vecs++;
    if (act != want) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic kick(input bit t);
    tick();
    test  = t;
    start = 1'b1;
    tick();
  endtask

  task automatic run_frame(input int maxc);
    int n = 0;
    do begin tick(); n++; end while (busy === 1'b1 && n < maxc);
    if (busy !== 1'b0) begin
      vecs++; errs++;
      $display("FAIL frame_timeout: busy=%b after %0d cycles, want 0", busy, n);
    end
    tick();
  endtask

  initial begin
    #(16 * 99000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    int ef0, n;
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;

    // full-length test frame, 1290 enable cycles per line
    pmode = 0; plen = 1290;
    ef0 = ef_seen;
    kick(1'b1);
    run_frame(30000);
    check("test_frame_end_frames", ef_seen - ef0, 1);
    check("test_frame_last_cnt", int'(line_cnt), TEST_LINES - 1);

    // normal frame with short lines
    plen = 8;
    ef0 = ef_seen;
    kick(1'b0);
    run_frame(20000);
    check("normal_frame_end_frames", ef_seen - ef0, 1);
    check("normal_frame_last_cnt", int'(line_cnt), NORMAL_LINES - 1);

    // test selection latched at start; start pulses mid-frame ignored
    ef0 = ef_seen;
    kick(1'b1);
    n = 0;
    while (line_cnt != 3 && n < 200) begin tick(); n++; end
    test = 1'b0;
    repeat (5) begin tick(); start = 1'b1; end
    run_frame(2000);
    check("latch_end_frames", ef_seen - ef0, 1);
    check("latch_last_cnt", int'(line_cnt), TEST_LINES - 1);

    // endLine held during IDLE and during gaps
    pmode = 3;
    repeat (6) tick();
    check("idle_endline_busy", int'(busy), 0);
    kick(1'b1);
    run_frame(2000);
    pmode = 0;

    // abort in the middle of line 5
    ef0 = ef_seen;
    kick(1'b1);
    n = 0;
    while (!(line_cnt == 5 && line_enb === 1'b1 && run == 3) && n < 500) begin tick(); n++; end
    abort   = 1'b1;
    endLine = 1'b1;
    tick();
    check("abort_enb", int'(line_enb), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_cnt", int'(line_cnt), 5);
    repeat (4) tick();
    check("abort_no_end_frame", ef_seen - ef0, 0);
    kick(1'b1);
    tick();
    check("restart_cnt", int'(line_cnt), 0);
    check("restart_busy", int'(busy), 1);
    run_frame(2000);

    // abort together with start in IDLE
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    check("abort_start_idle", int'(busy), 0);

    // randomized traffic
    pmode = 1;
    for (int i = 0; i < 15000; i++) begin
      tick();
      start = ($urandom_range(15) == 0);
      abort = ($urandom_range(399) == 0);
      if ($urandom_range(31) == 0) test = ~test;
      if (start) test = ($urandom_range(7) != 0);
    end

    // asynchronous reset in the middle of an active line
    pmode = 0; plen = 40;
    kick(1'b1);
    repeat (10) tick();
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_enb", int'(line_enb), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_cnt", int'(line_cnt), 0);
    check("async_reset_ef", int'(end_frame), 0);
    repeat (2) tick();
    #3 rst_n = 1'b1;
    plen = 8;
    kick(1'b1);
    run_frame(2000);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
